// File: rtl/invaes_round_ctrl.sv
// Round sequencer for the inverse-AES datapath: key expansion, then the inverse rounds, then done.
// Optional macro INVAES_SYNC_SBOX_EN: two-cycle KEYEXP/ROUND/FINAL steps for a registered S-box ROM.
module invaes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic       rk_we,
   output logic [3:0] rk_idx,
   output logic [7:0] rcon,
   output logic       state_we,
   output logic [1:0] st_sel
);

   typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL, DONE} state_t;

   localparam logic [3:0] NR_L = 4'(NR);

   state_t     state_reg, state_next;
   logic       load_q;
   logic [3:0] cnt_reg, cnt_next;
   logic [7:0] rcon_reg, rcon_next;
   logic       start;
   logic       step;

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   assign start = load_q & ~load;

`ifdef INVAES_SYNC_SBOX_EN
   logic phase_reg, phase_next;

   // Phase 0 waits for the S-box ROM read; phase 1 commits. INIT never toggles it.
   always_comb begin
      phase_next = 1'b0;
      if (busy && state_reg != INIT && !load)
         phase_next = ~phase_reg;
   end

   always_ff @(posedge clk) begin
      if (reset)
         phase_reg <= 1'b0;
      else
         phase_reg <= phase_next;
   end

   assign step = phase_reg;
`else
   assign step = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         load_q    <= 1'b0;
         cnt_reg   <= 4'd0;
         rcon_reg  <= 8'h00;
      end else begin
         state_reg <= state_next;
         load_q    <= load;
         cnt_reg   <= cnt_next;
         rcon_reg  <= rcon_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rcon_next  = rcon_reg;
      busy       = 1'b0;
      done       = 1'b0;
      rk_we      = 1'b0;
      rk_idx     = 4'd0;
      rcon       = 8'h00;
      state_we   = 1'b0;
      st_sel     = 2'd0;

      case (state_reg)
         IDLE, DONE: begin
            done = (state_reg == DONE);
            if (start) begin
               state_next = KEYEXP;
               cnt_next   = 4'd1;
               rcon_next  = 8'h01;
            end else if (state_reg == DONE && load) begin
               state_next = IDLE;
            end
         end

         KEYEXP: begin
            busy   = 1'b1;
            rk_we  = step;
            rk_idx = cnt_reg;
            rcon   = rcon_reg;
            if (load) begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end else if (step) begin
               if (cnt_reg == NR_L) begin
                  state_next = INIT;
               end else begin
                  cnt_next  = cnt_reg + 4'd1;
                  rcon_next = xtime(rcon_reg);
               end
            end
         end

         INIT: begin
            busy     = 1'b1;
            state_we = 1'b1;
            st_sel   = 2'd0;
            rk_idx   = NR_L;
            if (load) begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end else begin
               state_next = ROUND;
               cnt_next   = NR_L - 4'd1;
            end
         end

         ROUND: begin
            busy     = 1'b1;
            state_we = step;
            st_sel   = 2'd1;
            rk_idx   = cnt_reg;
            if (load) begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end else if (step) begin
               if (cnt_reg == 4'd1)
                  state_next = FINAL;
               else
                  cnt_next = cnt_reg - 4'd1;
            end
         end

         FINAL: begin
            busy     = 1'b1;
            state_we = step;
            st_sel   = 2'd2;
            rk_idx   = 4'd0;
            if (load) begin
               state_next = IDLE;
               cnt_next   = 4'd0;
            end else if (step) begin
               state_next = DONE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_invaes_round_ctrl.sv
// Directed bench for invaes_round_ctrl (NR=10): full run, abort, mid-run reset, back-to-back runs.
// Honours INVAES_SYNC_SBOX_EN for the two-cycle step timing.
module tb_invaes_round_ctrl;

   localparam int NR = 10;
`ifdef INVAES_SYNC_SBOX_EN
   localparam int LAT = 4*NR + 1;
`else
   localparam int LAT = 2*NR + 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic       busy, done, rk_we, state_we;
   logic [3:0] rk_idx;
   logic [7:0] rcon;
   logic [1:0] st_sel;
   logic [17:0] obs;

   int checks = 0;
   int errors = 0;

   logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   invaes_round_ctrl #(.NR(NR)) dut (
      .clk(clk), .reset(reset), .load(load),
      .busy(busy), .done(done), .rk_we(rk_we), .rk_idx(rk_idx),
      .rcon(rcon), .state_we(state_we), .st_sel(st_sel)
   );

   always #5 clk = ~clk;

   assign obs = {busy, done, rk_we, rk_idx, rcon, state_we, st_sel};

   // Expected {busy,done,rk_we,rk_idx,rcon,state_we,st_sel} n edges after the start edge.
   function automatic logic [17:0] exp_at(input int n);
      logic       b, d, rw, sw;
      logic [3:0] idx;
      logic [7:0] rc;
      logic [1:0] sel;
      int         m;
      b = 0; d = 0; rw = 0; sw = 0; idx = 0; rc = 0; sel = 0;
`ifdef INVAES_SYNC_SBOX_EN
      if (n < 2*NR) begin
         b = 1; idx = 4'(n/2 + 1); rc = rcon_tab[n/2]; rw = (n % 2 == 1);
      end else if (n == 2*NR) begin
         b = 1; sw = 1; idx = 4'(NR);
      end else if (n < 4*NR - 1) begin
         m = n - 2*NR - 1;
         b = 1; sel = 2'd1; idx = 4'(NR - 1 - m/2); sw = (m % 2 == 1);
      end else if (n < 4*NR + 1) begin
         b = 1; sel = 2'd2; sw = (n == 4*NR);
      end else begin
         d = 1;
      end
`else
      if (n < NR) begin
         b = 1; rw = 1; idx = 4'(n + 1); rc = rcon_tab[n];
      end else if (n == NR) begin
         b = 1; sw = 1; idx = 4'(NR);
      end else if (n < 2*NR) begin
         m = n - NR - 1;
         b = 1; sw = 1; sel = 2'd1; idx = 4'(NR - 1 - m);
      end else if (n == 2*NR) begin
         b = 1; sw = 1; sel = 2'd2;
      end else begin
         d = 1;
      end
`endif
      return {b, d, rw, idx, rc, sw, sel};
   endfunction

   task automatic start_run(input int hold);
      @(negedge clk);
      load = 1'b1;
      repeat (hold) @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      load  = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected %h", obs, 18'h0);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== 18'h0) begin
            errors++;
            $display("FAIL idle_no_start cycle=%0d got %h expected %h", i, obs, 18'h0);
         end
      end
      $display("test_reset complete");
   endtask

   task automatic test_full_run;
      logic [17:0] e;
      @(negedge clk);
      load = 1'b1;
      repeat (255) @(negedge clk);
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL load_high_idle got %h expected %h", obs, 18'h0);
      end
      load = 1'b0;
      for (int n = 0; n <= LAT + 3; n++) begin
         @(negedge clk);
         e = exp_at(n);
         checks++;
         $display("full n=%0d busy=%b done=%b rk_we=%b rk_idx=%0d rcon=%h state_we=%b st_sel=%0d",
                  n, busy, done, rk_we, rk_idx, rcon, state_we, st_sel);
         if (obs !== e) begin
            errors++;
            $display("FAIL full_run n=%0d got %h expected %h", n, obs, e);
         end
      end
      load = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL done_to_idle got %h expected %h", obs, 18'h0);
      end
   endtask

   task automatic test_abort;
      logic [17:0] e;
      start_run(3);
      for (int n = 0; n <= 13; n++) begin
         @(negedge clk);
         e = exp_at(n);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL abort_prefix n=%0d got %h expected %h", n, obs, e);
         end
      end
      load = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         $display("abort i=%0d busy=%b done=%b rk_we=%b state_we=%b", i, busy, done, rk_we, state_we);
         if (obs !== 18'h0) begin
            errors++;
            $display("FAIL abort_idle i=%0d got %h expected %h", i, obs, 18'h0);
         end
      end
      load = 1'b0;
      for (int n = 0; n <= LAT; n++) begin
         @(negedge clk);
         e = exp_at(n);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rerun_after_abort n=%0d got %h expected %h", n, obs, e);
         end
      end
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      // A single-cycle pulse from DONE passes through IDLE then restarts.
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL abort_done_exit got %h expected %h", obs, 18'h0);
      end
      @(negedge clk);
      checks++;
      if (obs !== exp_at(0)) begin
         errors++;
         $display("FAIL abort_pulse_restart got %h expected %h", obs, exp_at(0));
      end
      $display("test_abort complete");
   endtask

   task automatic test_reset_mid_run;
      logic [17:0] e;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start_run(2);
      for (int n = 0; n <= 4; n++) begin
         @(negedge clk);
         e = exp_at(n);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL midreset_prefix n=%0d got %h expected %h", n, obs, e);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      $display("midreset busy=%b done=%b rk_we=%b rk_idx=%0d rcon=%h", busy, done, rk_we, rk_idx, rcon);
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL midreset_outputs got %h expected %h", obs, 18'h0);
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== 18'h0) begin
            errors++;
            $display("FAIL midreset_stay_idle i=%0d got %h expected %h", i, obs, 18'h0);
         end
      end
   endtask

   task automatic test_back_to_back;
      int          seen;
      logic [17:0] e;
      seen = -1;
      start_run(1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1 && seen < 0) seen = i;
         if (seen >= 0) break;
      end
      checks++;
      $display("back_to_back done latency=%0d", seen);
      if (seen !== LAT) begin
         errors++;
         $display("FAIL done_latency got %0d expected %0d", seen, LAT);
      end
      load = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== 18'h0) begin
         errors++;
         $display("FAIL b2b_exit got %h expected %h", obs, 18'h0);
      end
      load = 1'b0;
      for (int n = 0; n <= LAT; n++) begin
         @(negedge clk);
         e = exp_at(n);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL b2b_run n=%0d got %h expected %h", n, obs, e);
         end
      end
      $display("test_back_to_back complete");
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_abort();
      test_reset_mid_run();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
